// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve
// Description : Branch unit for the RV32I pipeline. A direct-mapped branch
//               history table with 2-bit saturating counters and a branch
//               target buffer are looked up combinationally at fetch.
//               Control-flow instructions are resolved combinationally at
//               execute, which raises mispredict/redirect to the PC mux and
//               trains the tables at the next clock edge.
// Ports       : i_clk, i_rst (sync, active-high)
//               fetch  : i_fetch_pc -> o_pred_taken, o_pred_target
//               execute: i_ex_valid, i_ex_pc, i_ex_opcode, i_ex_funct3,
//                        i_br_less, i_br_equal, i_br_un, i_ex_target,
//                        i_ex_pred_taken, i_ex_pred_target
//                        -> o_ex_taken, o_mispredict, o_redirect_pc
//               perf   : o_br_count, o_mispred_count
// Config      : BP_PERF_CNT_EN enables the two 32-bit performance counters;
//               when undefined they are tied to zero and have no flops.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_resolve #(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_ex_valid,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [6:0]      i_ex_opcode,
    input  logic [2:0]      i_ex_funct3,
    input  logic            i_br_less,
    input  logic            i_br_equal,
    input  logic            i_br_un,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_ex_taken,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_br_count,
    output logic [31:0]     o_mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    // Table storage
    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_jump;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;

    assign w_f_idx = i_fetch_pc[IDX_W+1:2];
    assign w_f_tag = i_fetch_pc[XLEN-1:IDX_W+2];
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    // Jumps predict taken regardless of the counter.
    assign o_pred_taken  = w_f_hit && (r_jump[w_f_idx] || r_ctr[w_f_idx][1]);
    assign o_pred_target = o_pred_taken ? r_target[w_f_idx] : i_fetch_pc + c_PC_STEP;

    // ------------------------------------------------------------------
    // Execute resolution
    // ------------------------------------------------------------------
    logic w_is_branch;
    logic w_is_jump;
    logic w_is_cf;
    logic w_br_taken;

    assign w_is_branch = (i_ex_opcode == c_OP_BRANCH);
    assign w_is_jump   = (i_ex_opcode == c_OP_JAL) || (i_ex_opcode == c_OP_JALR);
    assign w_is_cf     = w_is_branch || w_is_jump;

    // i_br_un = 1 means the comparator ran a signed compare.
    always_comb begin
        w_br_taken = 1'b0;
        case (i_ex_funct3)
            3'b000:  w_br_taken = i_br_equal;
            3'b001:  w_br_taken = !i_br_equal;
            3'b100:  w_br_taken = i_br_un && i_br_less;
            3'b101:  w_br_taken = i_br_un && !i_br_less;
            3'b110:  w_br_taken = !i_br_un && i_br_less;
            3'b111:  w_br_taken = !i_br_un && !i_br_less;
            default: w_br_taken = 1'b0;
        endcase
    end

    assign o_ex_taken    = w_is_jump || (w_is_branch && w_br_taken);
    assign o_redirect_pc = o_ex_taken ? i_ex_target : i_ex_pc + c_PC_STEP;
    assign o_mispredict  = i_ex_valid &&
                           ((o_ex_taken != i_ex_pred_taken) ||
                            (o_ex_taken && (i_ex_target != i_ex_pred_target)));

    // ------------------------------------------------------------------
    // Table update
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_e_idx;
    logic [TAG_W-1:0] w_e_tag;
    logic             w_e_hit;

    assign w_e_idx = i_ex_pc[IDX_W+1:2];
    assign w_e_tag = i_ex_pc[XLEN-1:IDX_W+2];
    assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_jump  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i]    <= 2'b01;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (i_ex_valid) begin
            if (w_is_cf && w_e_hit) begin
                r_target[w_e_idx] <= i_ex_target;
                r_jump[w_e_idx]   <= w_is_jump;
                if (o_ex_taken) begin
                    if (r_ctr[w_e_idx] != 2'b11)
                        r_ctr[w_e_idx] <= r_ctr[w_e_idx] + 2'd1;
                end else begin
                    if (r_ctr[w_e_idx] != 2'b00)
                        r_ctr[w_e_idx] <= r_ctr[w_e_idx] - 2'd1;
                end
            end else if (w_is_cf && o_ex_taken) begin
                // Miss on a taken control-flow: allocate weakly taken.
                r_valid[w_e_idx]  <= 1'b1;
                r_tag[w_e_idx]    <= w_e_tag;
                r_target[w_e_idx] <= i_ex_target;
                r_jump[w_e_idx]   <= w_is_jump;
                r_ctr[w_e_idx]    <= 2'b10;
            end else if (!w_is_cf && w_e_hit) begin
                // A non-control instruction owns this PC: drop the stale entry.
                r_valid[w_e_idx] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef BP_PERF_CNT_EN
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            if (i_ex_valid && w_is_cf)
                r_br_count <= r_br_count + 32'd1;
            if (o_mispredict)
                r_mispred_count <= r_mispred_count + 32'd1;
        end
    end

    assign o_br_count      = r_br_count;
    assign o_mispred_count = r_mispred_count;
`else
    assign o_br_count      = '0;
    assign o_mispred_count = '0;
`endif

    // The low PC bits are always zero for aligned instructions.
    logic w_unused;
    assign w_unused = ^{i_fetch_pc[1:0], i_ex_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_resolve
// Description : Directed self-checking bench for branch_predict_resolve.
//               A 64-entry instance carries the main checks; a 4-entry
//               instance shares its stimulus to observe index aliasing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_resolve;

    localparam logic [6:0] c_BR   = 7'b1100011;
    localparam logic [6:0] c_JAL  = 7'b1101111;
    localparam logic [6:0] c_JALR = 7'b1100111;
    localparam logic [6:0] c_ADDI = 7'b0010011;
    localparam logic [6:0] c_OP   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_pc = '0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [6:0]  ex_opcode = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        br_less = 1'b0, br_equal = 1'b0, br_un = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;

    logic        pred_taken, ex_taken, mispredict;
    logic [31:0] pred_target, redirect_pc, br_count, mispred_count;
    logic        pred_taken4, ex_taken4, mispredict4;
    logic [31:0] pred_target4, redirect_pc4, br_count4, mispred_count4;

    int n_checks = 0;
    int n_errors = 0;
    int sb_br    = 0;
    int sb_mis   = 0;

    always #5 clk = ~clk;

    branch_predict_resolve #(.ENTRIES(64), .XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_fetch_pc(fetch_pc),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_ex_opcode(ex_opcode),
        .i_ex_funct3(ex_funct3), .i_br_less(br_less), .i_br_equal(br_equal),
        .i_br_un(br_un), .i_ex_target(ex_target),
        .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_target(ex_pred_target),
        .o_ex_taken(ex_taken), .o_mispredict(mispredict),
        .o_redirect_pc(redirect_pc), .o_br_count(br_count),
        .o_mispred_count(mispred_count)
    );

    branch_predict_resolve #(.ENTRIES(4), .XLEN(32)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_fetch_pc(fetch_pc),
        .o_pred_taken(pred_taken4), .o_pred_target(pred_target4),
        .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_ex_opcode(ex_opcode),
        .i_ex_funct3(ex_funct3), .i_br_less(br_less), .i_br_equal(br_equal),
        .i_br_un(br_un), .i_ex_target(ex_target),
        .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_target(ex_pred_target),
        .o_ex_taken(ex_taken4), .o_mispredict(mispredict4),
        .o_redirect_pc(redirect_pc4), .o_br_count(br_count4),
        .o_mispred_count(mispred_count4)
    );

    // Present one execute-stage instruction and check the resolution outputs
    // before the edge. The caller advances the clock with step().
    task automatic drive_ex(input string name, input logic v, input logic [31:0] pc,
                            input logic [6:0] op, input logic [2:0] f3,
                            input logic less, input logic eq, input logic un,
                            input logic [31:0] tgt, input logic pt, input logic [31:0] ptg,
                            input logic e_taken, input logic e_mis, input logic [31:0] e_redir);
        @(negedge clk);
        ex_valid = v; ex_pc = pc; ex_opcode = op; ex_funct3 = f3;
        br_less = less; br_equal = eq; br_un = un; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptg;
        #1;
        if (v) begin
            n_checks++;
            if (ex_taken !== e_taken) begin
                n_errors++;
                $display("FAIL %s taken: got %b want %b", name, ex_taken, e_taken);
            end
        end
        n_checks++;
        if (mispredict !== e_mis) begin
            n_errors++;
            $display("FAIL %s mispredict: got %b want %b", name, mispredict, e_mis);
        end
        n_checks++;
        if (redirect_pc !== e_redir) begin
            n_errors++;
            $display("FAIL %s redirect: got %h want %h", name, redirect_pc, e_redir);
        end
        if (v && (op == c_BR || op == c_JAL || op == c_JALR)) sb_br++;
        if (e_mis) sb_mis++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic e_taken, input logic [31:0] e_tgt);
        @(negedge clk);
        fetch_pc = pc;
        #1;
        n_checks++;
        if (pred_taken !== e_taken || pred_target !== e_tgt) begin
            n_errors++;
            $display("FAIL %s lookup: got %b/%h want %b/%h", name,
                     pred_taken, pred_target, e_taken, e_tgt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lookup("reset", 32'h100, 1'b0, 32'h104);
        drive_ex("reset_invalid", 1'b0, 32'h100, c_BR, 3'b000, 1'b0, 1'b1, 1'b0,
                 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80);
        step();
        n_checks++;
        if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", br_count, mispred_count);
        end
        lookup("invalid_no_update", 32'h100, 1'b0, 32'h104);
    endtask

    task automatic test_alias();
        drive_ex("beq_alloc", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b1, 1'b0,
                 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        step();
        drive_ex("addi_alias", 1'b1, 32'h110, c_ADDI, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h114);
        step();
        lookup("beq_trained", 32'h100, 1'b1, 32'h80);
        n_checks++;
        if (pred_taken4 !== 1'b1 || pred_target4 !== 32'h80) begin
            n_errors++;
            $display("FAIL alias_keep: got %b/%h want 1/00000080", pred_taken4, pred_target4);
        end
        lookup("alias_other", 32'h110, 1'b0, 32'h114);
        n_checks++;
        if (pred_taken4 !== 1'b0 || pred_target4 !== 32'h114) begin
            n_errors++;
            $display("FAIL alias_tag: got %b/%h want 0/00000114", pred_taken4, pred_target4);
        end
    endtask

    task automatic test_counter();
        // ctr 10 -> 01 -> 00 -> 00
        drive_ex("nt1", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h104);
        step();
        lookup("nt1_pred", 32'h100, 1'b0, 32'h104);
        drive_ex("nt2", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
        step();
        drive_ex("nt3", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
        step();
        lookup("nt3_pred", 32'h100, 1'b0, 32'h104);
        // 00 -> 01 (not taken) -> 10 (taken)
        drive_ex("t1", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b1, 1'b0,
                 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        step();
        lookup("t1_pred", 32'h100, 1'b0, 32'h104);
        drive_ex("t2", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b1, 1'b0,
                 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        step();
        lookup("t2_pred", 32'h100, 1'b1, 32'h80);
        // 10 -> 11 -> 11 (saturate) -> 10 -> 01
        drive_ex("t3", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b1, 1'b0,
                 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'h80);
        step();
        drive_ex("t4", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b1, 1'b0,
                 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'h80);
        step();
        drive_ex("nt4", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h104);
        step();
        lookup("sat_hi", 32'h100, 1'b1, 32'h80);
        // Same-cycle lookup of the entry being trained sees the old state.
        drive_ex("nt5", 1'b1, 32'h100, c_BR, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h104);
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_errors++;
            $display("FAIL same_cycle: got %b/%h want 1/00000080", pred_taken, pred_target);
        end
        step();
        lookup("nt5_pred", 32'h100, 1'b0, 32'h104);
    endtask

    task automatic test_compare();
        drive_ex("bltu_signed", 1'b1, 32'h140, c_BR, 3'b110, 1'b1, 1'b0, 1'b1,
                 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h144);
        step();
        drive_ex("blt_signed", 1'b1, 32'h144, c_BR, 3'b100, 1'b1, 1'b0, 1'b1,
                 32'h20, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
        step();
        drive_ex("bne", 1'b1, 32'h148, c_BR, 3'b001, 1'b0, 1'b0, 1'b0,
                 32'h30, 1'b1, 32'h30, 1'b1, 1'b0, 32'h30);
        step();
        drive_ex("bge", 1'b1, 32'h14c, c_BR, 3'b101, 1'b0, 1'b0, 1'b1,
                 32'h34, 1'b0, 32'h0, 1'b1, 1'b1, 32'h34);
        step();
        drive_ex("bgeu_less", 1'b1, 32'h150, c_BR, 3'b111, 1'b1, 1'b0, 1'b0,
                 32'h38, 1'b0, 32'h0, 1'b0, 1'b0, 32'h154);
        step();
        drive_ex("undef_f3", 1'b1, 32'h154, c_BR, 3'b010, 1'b0, 1'b1, 1'b0,
                 32'h3c, 1'b1, 32'h3c, 1'b0, 1'b1, 32'h158);
        step();
        lookup("undef_no_alloc", 32'h154, 1'b0, 32'h158);
        lookup("blt_alloc", 32'h144, 1'b1, 32'h20);
        drive_ex("add_wrap", 1'b1, 32'hFFFF_FFFC, c_OP, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        lookup("fetch_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    endtask

    task automatic test_jalr();
        drive_ex("jalr_alloc", 1'b1, 32'h200, c_JALR, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h400, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
        step();
        lookup("jalr_pred", 32'h200, 1'b1, 32'h400);
        drive_ex("jalr_retarget", 1'b1, 32'h200, c_JALR, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h500, 1'b1, 32'h400, 1'b1, 1'b1, 32'h500);
        step();
        lookup("jalr_new", 32'h200, 1'b1, 32'h500);
        drive_ex("jalr_hit", 1'b1, 32'h200, c_JALR, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h500, 1'b1, 32'h500, 1'b1, 1'b0, 32'h500);
        step();
        drive_ex("jal_alloc", 1'b1, 32'h220, c_JAL, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h600, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600);
        step();
        lookup("jal_pred", 32'h220, 1'b1, 32'h600);
        drive_ex("addi_inval", 1'b1, 32'h200, c_ADDI, 3'b000, 1'b0, 1'b0, 1'b0,
                 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h204);
        step();
        lookup("inval_pred", 32'h200, 1'b0, 32'h204);
    endtask

    task automatic test_perf();
        logic [31:0] e_br, e_mis;
`ifdef BP_PERF_CNT_EN
        e_br  = 32'(sb_br);
        e_mis = 32'(sb_mis);
`else
        e_br  = 32'd0;
        e_mis = 32'd0;
`endif
        n_checks++;
        if (br_count !== e_br) begin
            n_errors++;
            $display("FAIL perf_br: got %0d want %0d", br_count, e_br);
        end
        n_checks++;
        if (mispred_count !== e_mis) begin
            n_errors++;
            $display("FAIL perf_mis: got %0d want %0d", mispred_count, e_mis);
        end
    endtask

    task automatic test_reset_mid();
        // A taken JAL at the same edge as reset must not allocate.
        @(negedge clk);
        rst = 1'b1;
        ex_valid = 1'b1; ex_pc = 32'h300; ex_opcode = c_JAL; ex_target = 32'h700;
        ex_pred_taken = 1'b0;
        step();
        rst = 1'b0;
        sb_br = 0;
        sb_mis = 0;
        lookup("rst_mid_disc", 32'h300, 1'b0, 32'h304);
        lookup("rst_mid_clear", 32'h144, 1'b0, 32'h148);
        test_perf();
    endtask

    initial begin
        test_reset();
        test_alias();
        test_counter();
        test_compare();
        test_jalr();
        test_perf();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised branch unit for the RV32I pipeline: a direct-mapped branch history table (2-bit saturating counters) plus branch target buffer is looked up at fetch, and control-flow instructions are resolved at execute. Resolution uses the comparator flags (less/equal/un) and opcode/funct3. The unit raises a mispredict/redirect to the PC mux and trains the tables on every resolved control-flow instruction. It replaces the purely combinational taken logic with predicted fetch.

## Interface
- ENTRIES, 64: table depth, power of two, 4..1024; IDX_W = log2(ENTRIES)
- XLEN, 32: address width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_fetch_pc  in  XLEN  fetch-stage PC
- o_pred_taken  out  1  predicted taken for i_fetch_pc
- o_pred_target  out  XLEN  predicted target (pc+4 when not taken)
- i_ex_valid  in  1  execute-stage instruction valid (not bubble/flushed)
- i_ex_pc  in  XLEN  execute-stage PC
- i_ex_opcode  in  7  opcode[6:0]
- i_ex_funct3  in  3  funct3
- i_br_less, i_br_equal  in  1 each  comparator flags
- i_br_un  in  1  1 = signed compare performed, 0 = unsigned
- i_ex_target  in  XLEN  computed target (pc+imm, or rs1+imm with bit0 cleared for JALR)
- i_ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- i_ex_pred_target  in  XLEN  predicted target carried down
- o_ex_taken  out  1  actual outcome
- o_mispredict  out  1  flush fetch/decode and redirect
- o_redirect_pc  out  XLEN  correct next PC
- o_br_count, o_mispred_count  out  32 each  perf counters (macro only)

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. Each entry: valid, tag, jump bit, 2-bit counter, target.
- Lookup (combinational): hit = valid && tag match; o_pred_taken = hit && (jump || ctr[1]); o_pred_target = o_pred_taken ? target : i_fetch_pc+4.
- Actual taken: B-type (1100011) with BEQ&equal, BNE&!equal, BLT&un&less, BGE&un&!less, BLTU&!un&less, BGEU&!un&!less; JAL (1101111) and JALR (1100111) always taken; anything else not taken. Undefined funct3 (010, 011) = not taken.
- o_redirect_pc = o_ex_taken ? i_ex_target : i_ex_pc+4 (mod 2^XLEN).
- o_mispredict = i_ex_valid && (o_ex_taken != i_ex_pred_taken || (o_ex_taken && i_ex_target != i_ex_pred_target)). Forced 0 when i_ex_valid=0.
- Update at clock edge when i_ex_valid, on the entry at i_ex_pc:
  - control-flow, hit: target <= i_ex_target; branch counter saturating +1 if taken, -1 if not (00..11); jump bit <= opcode is JAL/JALR.
  - control-flow, miss, taken: allocate (overwrite) with valid=1, new tag/target, ctr=10 (weakly taken), jump bit set accordingly.
  - control-flow, miss, not taken: no write.
  - non-control instruction, hit: valid <= 0 (aliasing clean-up); miss: no write.
- Reset: all valid=0, all ctr=01, targets/tags 0; o_pred_taken=0, o_pred_target=i_fetch_pc+4, perf counters 0. Combinational outputs follow their inputs after reset.

## Timing
- Lookup and resolution: 0-cycle combinational. Table write: visible to lookup on the cycle after the edge.
- Same-cycle lookup and update of one index: lookup returns pre-update contents.
- Reset asserted mid-operation: the pending update in that cycle is discarded; reset wins.
- Counter saturation: 11 + taken stays 11; 00 + not-taken stays 00.

## Configuration
- BP_PERF_CNT_EN defined: o_br_count increments on each i_ex_valid control-flow instruction; o_mispred_count increments on each o_mispredict. Both are 32-bit wrapping counters, cleared by i_rst.
- Not defined: both ports are tied to 0 and no counter flops are present.

## Test plan
- Reset, then i_fetch_pc=0x100 -> o_pred_taken=0, o_pred_target=0x104; o_mispredict=0 with i_ex_valid=0.
- BEQ at 0x100, equal=1, target 0x80, pred_taken=0 -> o_mispredict=1, redirect 0x80. Next cycle fetch 0x100 -> pred_taken=1, target 0x80.
- Same BEQ resolved not-taken three times -> ctr goes 10→01→00→00; prediction is not-taken from the first; o_mispredict only when carried pred mismatches.
- BLTU with un=1, less=1 -> not taken, redirect pc+4. BLT with un=1, less=1 -> taken.
- JALR at 0x200 trained to 0x400, then resolved to 0x500 with pred target 0x400 -> o_mispredict=1, redirect 0x500, entry target updated.
- ENTRIES=4: 0x100 and 0x110 alias; ADDI at 0x110 after 0x100 trained -> no invalidate (tag differs). With BP_PERF_CNT_EN, counters match the scoreboard totals.
